key_repeat_interpreter: RTL and testbench

KEY_REPEAT_INTERPRETER -- requirements
Module: key_repeat_interpreter

---
 rtl/key_repeat_interpreter_if.sv | 48 ++++
 rtl/key_repeat_interpreter.sv | 167 ++++++++++++++++
 tb/tb_key_repeat_interpreter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/key_repeat_interpreter_if.sv
// Key event bus between a scan-code decoder and key_repeat_interpreter.
//
// Decoder side (master) drives one event per cycle on valid/makeBreak/outCode.
// Interpreter side (slave) returns one-cycle move/select pulses and the set of
// currently held keys.
//   valid        event strobe, qualifies makeBreak and outCode
//   makeBreak    1 = key pressed (make), 0 = key released (break)
//   outCode      8-bit scan code
//   moveXxxEn    one-cycle direction pulses (right/left/up/down)
//   selectEn     one-cycle select pulse
//   heldKeys     held state: [0] right, [1] left, [2] up, [3] down, [4] select
interface key_repeat_interpreter_if;

  logic       valid;
  logic       makeBreak;
  logic [7:0] outCode;
  logic       moveRightEn;
  logic       moveLeftEn;
  logic       moveUpEn;
  logic       moveDownEn;
  logic       selectEn;
  logic [4:0] heldKeys;

  modport master (
    output valid,
    output makeBreak,
    output outCode,
    input  moveRightEn,
    input  moveLeftEn,
    input  moveUpEn,
    input  moveDownEn,
    input  selectEn,
    input  heldKeys
  );

  modport slave (
    input  valid,
    input  makeBreak,
    input  outCode,
    output moveRightEn,
    output moveLeftEn,
    output moveUpEn,
    output moveDownEn,
    output selectEn,
    output heldKeys
  );

endinterface

// File: rtl/key_repeat_interpreter.sv
// Turns keyboard make/break events into one-cycle move/select pulses with
// optional hold-to-repeat on the four direction keys.
//
// A fresh press of a direction key pulses immediately, then (when REPEAT_EN
// is set) again after DELAY_CYCLES and every PERIOD_CYCLES while it stays the
// active direction. The newest direction press always takes over; releasing
// the active direction stops repeating without falling back to other keys.
// Select pulses once per press and never repeats.
//
// Ports:
//   clk      rising-edge clock
//   resetn   synchronous active-low reset
//   bus      key event bus (slave side): valid/makeBreak/outCode in,
//            move/select pulses and heldKeys out (all registered)
module key_repeat_interpreter #(
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned DELAY_CYCLES  = 25000000,
  parameter int unsigned PERIOD_CYCLES = 5000000,
  parameter int unsigned CNT_W         = 25
) (
  input logic                     clk,
  input logic                     resetn,
  key_repeat_interpreter_if.slave bus
);

  localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [2:0]       SelectIdx  = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat
  } state_e;

  state_e           stateQ, stateD;
  logic [CNT_W-1:0] timerQ, timerD;
  logic [1:0]       activeQ, activeD;
  logic [4:0]       heldQ, heldD;
  logic [3:0]       moveQ, moveD;
  logic             selectQ, selectD;

  // Scan code decode: index matches the heldKeys bit position.
  logic       keyHit;
  logic [2:0] keyIdx;

  always_comb begin
    keyHit = 1'b1;
    keyIdx = 3'd0;
    case (bus.outCode)
      8'h74:   keyIdx = 3'd0;
      8'h6B:   keyIdx = 3'd1;
      8'h75:   keyIdx = 3'd2;
      8'h72:   keyIdx = 3'd3;
      8'h5A:   keyIdx = SelectIdx;
      default: keyHit = 1'b0;
    endcase
  end

  logic       keyEvent;
  logic       isDir;
  logic [1:0] dirIdx;

  assign keyEvent = bus.valid && keyHit;
  assign isDir    = (keyIdx != SelectIdx);
  assign dirIdx   = keyIdx[1:0];

  logic expiry;
  logic takeover;

  always_comb begin
    stateD   = stateQ;
    timerD   = timerQ;
    activeD  = activeQ;
    heldD    = heldQ;
    moveD    = 4'b0000;
    selectD  = 1'b0;
    expiry   = 1'b0;
    takeover = 1'b0;

    // Free-running timer behaviour when no event intervenes.
    unique case (stateQ)
      StIdle: begin
        timerD = '0;
      end
      StDelay: begin
        if (timerQ == DelayLast) begin
          expiry = 1'b1;
          timerD = '0;
          stateD = StRepeat;
        end else begin
          timerD = timerQ + 1'b1;
        end
      end
      StRepeat: begin
        if (timerQ == PeriodLast) begin
          expiry = 1'b1;
          timerD = '0;
        end else begin
          timerD = timerQ + 1'b1;
        end
      end
      default: begin
        stateD = StIdle;
        timerD = '0;
      end
    endcase

    // Events that touch the FSM override the timer result above. Typematic
    // duplicates and breaks of non-active keys leave the timer running.
    if (keyEvent) begin
      if (bus.makeBreak) begin
        if (!heldQ[keyIdx]) begin
          heldD[keyIdx] = 1'b1;
          if (isDir) begin
            takeover       = 1'b1;
            activeD        = dirIdx;
            timerD         = '0;
            stateD         = (REPEAT_EN != 0) ? StDelay : StIdle;
            moveD[dirIdx]  = 1'b1;
          end else begin
            selectD = 1'b1;
          end
        end
      end else begin
        heldD[keyIdx] = 1'b0;
        if (isDir && (dirIdx == activeQ)) begin
          takeover = 1'b1;
          stateD   = StIdle;
          timerD   = '0;
        end
      end
    end

    // A select pulse wins over a coincident repeat pulse so the two never
    // overlap; the repeat schedule itself is unaffected.
    if (expiry && !takeover && !selectD) begin
      moveD[activeQ] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stateQ  <= StIdle;
      timerQ  <= '0;
      activeQ <= 2'd0;
      heldQ   <= 5'b00000;
      moveQ   <= 4'b0000;
      selectQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      timerQ  <= timerD;
      activeQ <= activeD;
      heldQ   <= heldD;
      moveQ   <= moveD;
      selectQ <= selectD;
    end
  end

  assign bus.moveRightEn = moveQ[0];
  assign bus.moveLeftEn  = moveQ[1];
  assign bus.moveUpEn    = moveQ[2];
  assign bus.moveDownEn  = moveQ[3];
  assign bus.selectEn    = selectQ;
  assign bus.heldKeys    = heldQ;

endmodule

// File: tb/tb_key_repeat_interpreter.sv
// Randomized scoreboard bench for key_repeat_interpreter. Two instances share
// the same stimulus: instance A repeats (DELAY=4, PERIOD=2), instance B has
// repeat disabled. The reference model tracks held keys and the press time of
// the active direction; repeat pulses fall at press + DELAY + k*PERIOD.
module tb_key_repeat_interpreter;

  localparam int Delay  = 4;
  localparam int Period = 2;

  logic       clk;
  logic       resetn;
  logic       valid;
  logic       makeBreak;
  logic [7:0] outCode;

  key_repeat_interpreter_if busA ();
  key_repeat_interpreter_if busB ();

  assign busA.valid     = valid;
  assign busA.makeBreak = makeBreak;
  assign busA.outCode   = outCode;
  assign busB.valid     = valid;
  assign busB.makeBreak = makeBreak;
  assign busB.outCode   = outCode;

  key_repeat_interpreter #(
    .REPEAT_EN    (1),
    .DELAY_CYCLES (Delay),
    .PERIOD_CYCLES(Period),
    .CNT_W        (3)
  ) dutA (
    .clk   (clk),
    .resetn(resetn),
    .bus   (busA)
  );

  key_repeat_interpreter #(
    .REPEAT_EN    (0),
    .DELAY_CYCLES (Delay),
    .PERIOD_CYCLES(Period),
    .CNT_W        (3)
  ) dutB (
    .clk   (clk),
    .resetn(resetn),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs per edge, packed {heldKeys, select, down, up, left, right}.
  logic [9:0] expQA[$];
  logic [9:0] expQB[$];

  // Reference model state, one slot per instance.
  int         edgeNo = 0;
  logic [4:0] mHeld[2];
  int         mActive[2];
  bit         mRun[2];
  int         mAnchor[2];

  logic [7:0] codes[5] = '{8'h74, 8'h6B, 8'h75, 8'h72, 8'h5A};

  task automatic modelStep(input int inst, input bit repEn, input logic rn, input logic v,
                           input logic mb, input logic [7:0] code, output logic [9:0] expv);
    int         idx;
    logic [3:0] mv;
    logic       sel;
    bit         take;
    mv   = 4'b0000;
    sel  = 1'b0;
    take = 1'b0;
    if (!rn) begin
      mHeld[inst]   = 5'b00000;
      mActive[inst] = 0;
      mRun[inst]    = 1'b0;
      expv = 10'd0;
      return;
    end
    idx = -1;
    for (int k = 0; k < 5; k++) if (code == codes[k]) idx = k;
    if (v && idx >= 0) begin
      if (mb) begin
        if (!mHeld[inst][idx]) begin
          mHeld[inst][idx] = 1'b1;
          if (idx == 4) begin
            sel = 1'b1;
          end else begin
            take          = 1'b1;
            mv[idx]       = 1'b1;
            mActive[inst] = idx;
            mRun[inst]    = repEn;
            mAnchor[inst] = edgeNo;
          end
        end
      end else begin
        mHeld[inst][idx] = 1'b0;
        if (idx < 4 && idx == mActive[inst] && mRun[inst]) begin
          take       = 1'b1;
          mRun[inst] = 1'b0;
        end
      end
    end
    if (!take && !sel && mRun[inst] && edgeNo >= mAnchor[inst] + Delay &&
        ((edgeNo - mAnchor[inst] - Delay) % Period) == 0)
      mv[mActive[inst]] = 1'b1;
    expv = {mHeld[inst], sel, mv};
  endtask

  // Drive one cycle of inputs and queue the expected response for that edge.
  task automatic step(input logic rn, input logic v, input logic mb, input logic [7:0] code);
    logic [9:0] ea, eb;
    @(negedge clk);
    resetn    = rn;
    valid     = v;
    makeBreak = mb;
    outCode   = code;
    modelStep(0, 1'b1, rn, v, mb, code, ea);
    modelStep(1, 1'b0, rn, v, mb, code, eb);
    expQA.push_back(ea);
    expQB.push_back(eb);
    edgeNo++;
  endtask

  // Idle cycles carry garbage on makeBreak/outCode with valid low.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'($urandom), 8'($urandom));
  endtask

  task automatic press(input logic [7:0] code);
    step(1'b1, 1'b1, 1'b1, code);
  endtask

  task automatic release_key(input logic [7:0] code);
    step(1'b1, 1'b1, 1'b0, code);
  endtask

  // Monitor: compare every edge that has a queued expectation.
  initial begin
    logic [9:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expQA.size() > 0) begin
        e = expQA.pop_front();
        a = {busA.heldKeys, busA.selectEn, busA.moveDownEn, busA.moveUpEn,
             busA.moveLeftEn, busA.moveRightEn};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs_repeat t=%0t: got %b, expected %b", $time, a, e);
        end
      end
      if (expQB.size() > 0) begin
        e = expQB.pop_front();
        a = {busB.heldKeys, busB.selectEn, busB.moveDownEn, busB.moveUpEn,
             busB.moveLeftEn, busB.moveRightEn};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs_norepeat t=%0t: got %b, expected %b", $time, a, e);
        end
      end
    end
  end

  initial begin
    int r;
    int k;
    resetn    = 1'b0;
    valid     = 1'b0;
    makeBreak = 1'b0;
    outCode   = 8'h00;

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

    // Hold right: pulse, then delay, then periodic repeats.
    press(8'h74);
    idle(12);
    // Typematic duplicates must not disturb timing.
    for (int i = 0; i < 4; i++) begin
      press(8'h74);
      idle(2);
    end
    release_key(8'h74);
    idle(3);

    // Right repeating, left takes over, releases in both orders.
    press(8'h74);
    idle(8);
    press(8'h6B);
    idle(6);
    release_key(8'h74);
    idle(6);
    release_key(8'h6B);
    idle(3);

    // Select: single pulse, held bit, release.
    press(8'h5A);
    idle(4);
    press(8'h5A);
    idle(2);
    release_key(8'h5A);
    idle(2);

    // Up held with typematic for 20 cycles.
    press(8'h75);
    for (int i = 0; i < 6; i++) begin
      idle(2);
      press(8'h75);
    end
    release_key(8'h75);
    idle(2);

    // Reset in the middle of repeating, then ignored code and stale break.
    press(8'h72);
    idle(8);
    step(1'b0, 1'b1, 1'b1, 8'h72);
    step(1'b1, 1'b1, 1'b1, 8'h1C);
    idle(2);
    release_key(8'h74);
    press(8'h72);
    idle(7);
    release_key(8'h72);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
      end else if (r < 35) begin
        k = int'($urandom_range(0, 6));
        step(1'b1, 1'b1, ($urandom_range(0, 2) != 0),
             (k < 5) ? codes[k] : 8'($urandom));
      end else begin
        idle(1);
      end
    end
    idle(2);

    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (expQA.size() != 0 || expQB.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", expQA.size(), expQB.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
